// File: rtl/taint_pkg.sv
// Shared constants and the state encoding for the taint sink.
package taint_pkg;

    localparam logic [63:0] TAG_MASK   = 64'h8000000040000000;
    localparam int          TAG_HI_DEF = 63;
    localparam int          TAG_LO_DEF = 30;

    typedef enum logic [1:0] {
        CLEAN   = 2'd0,
        TAINTED = 2'd1,
        ALARM   = 2'd2
    } state_t;

endpackage

// File: rtl/taint_pipe_reg.sv
// One-entry valid/ready register slice. in_ready_o = ~out_valid_o | out_ready_i; a word
// transfers on in_valid_i & in_ready_o, and payload stays stable while out_valid_o & ~out_ready_i.
module taint_pipe_reg #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            data_q  <= in_data_i;
            valid_q <= 1'b1;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/taint_sink.sv
// Taint sink: registers words, classifies clean/tainted/malformed, counts and raises a sticky alarm.
// Optional macro TAINT_SINK_DROP_EN: tainted words are counted but not forwarded.
module taint_sink
    import taint_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int TAG_HI = TAG_HI_DEF,
    parameter int TAG_LO = TAG_LO_DEF,
    parameter int CNT_W  = 16,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_taint,
    output logic [CNT_W-1:0] taint_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             alarm,
    input  logic             clr,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    logic             tag;
    logic             malformed;
    logic             accept;
    logic             load_valid;
    logic             slice_ready;

    state_t           state_q, state_d, state_base;
    logic [CNT_W-1:0] taint_cnt_q, taint_cnt_d, taint_base;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d, bad_base;
    logic             alarm_q;

    assign tag       = i[TAG_HI] & i[TAG_LO];
    assign malformed = i[TAG_HI] ^ i[TAG_LO];
    assign i_ready   = slice_ready;
    assign accept    = i_valid & i_ready;

`ifdef TAINT_SINK_DROP_EN
    // Tainted words are still handshaken so upstream never stalls on them.
    assign load_valid = i_valid & ~tag;
`else
    assign load_valid = i_valid;
`endif

    taint_pipe_reg #(.W(WIDTH + 1)) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  ({tag, i}),
        .in_valid_i (load_valid),
        .in_ready_o (slice_ready),
        .out_data_o ({o_taint, o}),
        .out_valid_o(o_valid),
        .out_ready_i(o_ready)
    );

    // clr acts first, then the word accepted in the same cycle is counted.
    always_comb begin
        taint_base  = clr ? '0 : taint_cnt_q;
        bad_base    = clr ? '0 : bad_cnt_q;
        state_base  = clr ? CLEAN : state_q;
        taint_cnt_d = taint_base;
        bad_cnt_d   = bad_base;
        state_d     = state_base;
        if (accept && tag && (taint_base != '1)) begin
            taint_cnt_d = taint_base + 1'b1;
        end
        if (accept && malformed && (bad_base != '1)) begin
            bad_cnt_d = bad_base + 1'b1;
        end
        if (accept && tag && (state_base != ALARM)) begin
            state_d = (taint_cnt_d >= THRESH_C) ? ALARM : TAINTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAN;
            taint_cnt_q <= '0;
            bad_cnt_q   <= '0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            taint_cnt_q <= taint_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            alarm_q     <= (state_d == ALARM);
        end
    end

    assign taint_cnt = taint_cnt_q;
    assign bad_cnt   = bad_cnt_q;
    assign alarm     = alarm_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_taint_sink.sv
// Bench for taint_sink: a default instance and a CNT_W=2/THRESH=2 instance share the stimulus.
module tb_taint_sink;
  import taint_pkg::*;

  logic        clk;
  logic        rst;
  logic [63:0] i;
  logic        i_valid;
  logic        o_ready;
  logic        clr;

  logic        i_ready, o_valid, o_taint, alarm;
  logic [63:0] o;
  logic [15:0] taint_cnt, bad_cnt;
  logic [1:0]  state_dbg;

  logic        i_ready2, o_valid2, o_taint2, alarm2;
  logic [63:0] o2;
  logic [1:0]  taint_cnt2, bad_cnt2;
  logic [1:0]  state_dbg2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // model state
  logic [63:0] m_o;
  bit          m_ov, m_ot;
  int          m_tc, m_bc, m_tc2, m_bc2;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  taint_sink u_dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .o(o), .o_valid(o_valid), .o_ready(o_ready), .o_taint(o_taint),
    .taint_cnt(taint_cnt), .bad_cnt(bad_cnt), .alarm(alarm), .clr(clr),
    .state_dbg(state_dbg)
  );

  taint_sink #(.CNT_W(2), .THRESH(2)) u_sat (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready2),
    .o(o2), .o_valid(o_valid2), .o_ready(o_ready), .o_taint(o_taint2),
    .taint_cnt(taint_cnt2), .bad_cnt(bad_cnt2), .alarm(alarm2), .clr(clr),
    .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int exp_state(input int tc, input int th);
    if (tc >= th) return int'(ALARM);
    if (tc > 0)   return int'(TAINTED);
    return int'(CLEAN);
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("i_ready",   {63'd0, i_ready},   {63'd0, (!m_ov) || o_ready});
      chk("o_valid",   {63'd0, o_valid},   {63'd0, m_ov});
      chk("o",         o,                  m_o);
      chk("o_taint",   {63'd0, o_taint},   {63'd0, m_ot});
      chk("taint_cnt", {48'd0, taint_cnt}, 64'(m_tc));
      chk("bad_cnt",   {48'd0, bad_cnt},   64'(m_bc));
      chk("alarm",     {63'd0, alarm},     {63'd0, m_tc >= 4});
      chk("state",     {62'd0, state_dbg}, 64'(exp_state(m_tc, 4)));
      chk("sat_o_valid",   {63'd0, o_valid2},   {63'd0, m_ov});
      chk("sat_taint_cnt", {62'd0, taint_cnt2}, 64'(m_tc2));
      chk("sat_bad_cnt",   {62'd0, bad_cnt2},   64'(m_bc2));
      chk("sat_alarm",     {63'd0, alarm2},     {63'd0, m_tc2 >= 2});
      chk("sat_state",     {62'd0, state_dbg2}, 64'(exp_state(m_tc2, 2)));
    end
  end

  // ---------------- driver: advance one clock and update the model ----------------
  task automatic tick();
    logic [63:0] n_o;
    bit n_ov, n_ot, acc, tg, bad, drop;
    int n_tc, n_bc, n_tc2, n_bc2;
    n_o = m_o; n_ov = m_ov; n_ot = m_ot;
    n_tc = m_tc; n_bc = m_bc; n_tc2 = m_tc2; n_bc2 = m_bc2;
    acc = i_valid && (!m_ov || o_ready);
    tg  = i[63] && i[30];
    bad = i[63] != i[30];
`ifdef TAINT_SINK_DROP_EN
    drop = tg;
`else
    drop = 1'b0;
`endif
    if (rst) begin
      n_o = '0; n_ov = 0; n_ot = 0; n_tc = 0; n_bc = 0; n_tc2 = 0; n_bc2 = 0;
    end else begin
      if (clr) begin
        n_tc = 0; n_bc = 0; n_tc2 = 0; n_bc2 = 0;
      end
      if (acc && tg) begin
        n_tc = sat_inc(n_tc, 65535); n_tc2 = sat_inc(n_tc2, 3);
      end
      if (acc && bad) begin
        n_bc = sat_inc(n_bc, 65535); n_bc2 = sat_inc(n_bc2, 3);
      end
      if (acc && !drop) begin
        n_o = i; n_ov = 1; n_ot = tg;
      end else if (m_ov && o_ready) begin
        n_ov = 0;
      end
    end
    @(posedge clk);
    #1;
    m_o = n_o; m_ov = n_ov; m_ot = n_ot;
    m_tc = n_tc; m_bc = n_bc; m_tc2 = n_tc2; m_bc2 = n_bc2;
  endtask

  task automatic drive(input logic [63:0] w, input bit v, input bit rdy, input bit c);
    i = w; i_valid = v; o_ready = rdy; clr = c;
  endtask

  function automatic logic [63:0] rand_word(input int cls);
    logic [63:0] w;
    w = {$urandom, $urandom};
    case (cls)
      0: begin w[63] = 0; w[30] = 0; end
      1: begin w[63] = 1; w[30] = 1; end
      2: begin w[63] = 1; w[30] = 0; end
      default: begin w[63] = 0; w[30] = 1; end
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    m_o = '0; m_ov = 0; m_ot = 0; m_tc = 0; m_bc = 0; m_tc2 = 0; m_bc2 = 0;
    rst = 1;
    drive(64'd0, 0, 1, 0);
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("reset_o_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_taint_cnt", {48'd0, taint_cnt}, 64'd0);

    // 1: clean word, 1-cycle latency
    drive(64'h0000000000001234, 1, 1, 0);
    tick();
    chk("t1_o", o, 64'h1234);
    chk("t1_o_valid", {63'd0, o_valid}, 64'd1);
    chk("t1_o_taint", {63'd0, o_taint}, 64'd0);

    // 2: four tainted back-to-back
    drive(64'h8000000140000000, 1, 1, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("t2_alarm_before", {63'd0, alarm}, 64'd0);
    tick();
    chk("t2_taint_cnt", {48'd0, taint_cnt}, 64'd4);
    chk("t2_alarm", {63'd0, alarm}, 64'd1);
    chk("t2_state", {62'd0, state_dbg}, 64'(int'(ALARM)));
    chk("t2_sat_cnt", {62'd0, taint_cnt2}, 64'd3);

    // 3: backpressure with held word, then release
    drive(64'h00000000000000AB, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
`ifndef TAINT_SINK_DROP_EN
      chk("t3_o_stable", o, 64'h8000000140000000);
`endif
      chk("t3_i_ready", {63'd0, i_ready}, 64'd0);
    end
    drive(64'h00000000000000AB, 1, 1, 0);
    tick();
    chk("t3_o_new", o, 64'hAB);

    // 4: malformed
    drive(64'h8000000000000000, 1, 1, 0);
    tick();
    chk("t4_bad_cnt", {48'd0, bad_cnt}, 64'd1);
    chk("t4_o_taint", {63'd0, o_taint}, 64'd0);
    chk("t4_taint_cnt", {48'd0, taint_cnt}, 64'd4);

    // 5: clr together with a tainted accept while in ALARM
    drive(64'hC000000040000000, 1, 1, 1);
    tick();
    chk("t5_taint_cnt", {48'd0, taint_cnt}, 64'd1);
    chk("t5_state", {62'd0, state_dbg}, 64'(int'(TAINTED)));
    chk("t5_alarm", {63'd0, alarm}, 64'd0);
    chk("t5_bad_cnt", {48'd0, bad_cnt}, 64'd0);

    // 6: alternating clean/tainted
    for (int k = 0; k < 8; k++) begin
      drive(rand_word(k % 2), 1, 1, 0);
      tick();
    end
    drive(64'd0, 0, 1, 0);
    tick();

    // randomized phase
    for (int k = 0; k < 600; k++) begin
      drive(rand_word($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 150) == 0);
      tick();
      rst = 0;
    end
    // long tainted burst to exercise 16-bit counter growth without clr
    for (int k = 0; k < 40; k++) begin
      drive(rand_word(1), 1, 1, 0);
      tick();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
